sync_pulse_gen: RTL and testbench
=================================

Name: sync_pulse_gen

Overview:
Programmable three-channel sync pulse transmitter in the 48 MHz clk domain. It is the generating end of the sync0/sync1/sync2 lines consumed by cntr_module, which measures min/max intervals. Per channel it sets delay from start, pulse width, period and pulse count, with a common master start and stop so all channels are phase-aligned. Runtime-configurable replacement for fixed-interval stimulus; usable on board and in benches.

Parameters:
CW, 32, width of delay/width/period/count registers and counters
DEF_DELAY, 0, reset value of every channel's delay register (clk cycles)
DEF_WIDTH, 1, reset value of every channel's width register (clk cycles)
DEF_PERIOD, 48_000, reset value of every channel's period register (clk cycles, rise to rise)
DEF_COUNT, 0, reset value of every channel's count register (0 = continuous)

Ports:
clk  in  1  48 MHz clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle strobe; loads active config and arms all channels
stop  in  1  one-cycle strobe; aborts all channels
cfg_we  in  1  shadow register write enable
cfg_ch  in  2  channel select 0..2 (3 = write ignored)
cfg_addr  in  2  0=delay, 1=width, 2=period, 3=count
cfg_data  in  CW  write data
sync0  out  1  channel 0 pulse output (registered)
sync1  out  1  channel 1 pulse output (registered)
sync2  out  1  channel 2 pulse output (registered)
busy  out  3  per-channel active flag, bit i = channel i

Behaviour:
- Reset (rst=0, async): sync0..2=0, busy=0, all FSMs IDLE, shadow regs = DEF_* values.
- Config: cfg_we writes shadow[cfg_ch][cfg_addr] at the clock edge. Shadow values never affect a running channel. They are copied to the active regs only on start. A write in the same cycle as start is not part of that run.
- Sanitising at start copy: width 0 is treated as 1. If period <= width, period becomes width+1 so the low phase is at least 1 cycle.
- Per-channel FSM states: IDLE, DELAY, HIGH, LOW.
- Start sampled high at edge N: every channel leaves its current state and enters DELAY, busy=1 from N+1. The output rises at edge N+1+D (D=delay; D=0 means high from N+1). It stays high W cycles, then goes low for P-W cycles, then rises again.
- Pulse counter: incremented on each rising edge of the output. With C>0, after the C-th pulse's HIGH phase ends, the channel goes IDLE. busy clears on the same edge the output falls. C=0 runs until stop, start or reset.
- Stop sampled high at edge N: all channels go IDLE, outputs 0 and busy 0 from N+1. A pulse in progress is truncated.
- Start and stop in the same cycle: stop wins; the cycle is a plain stop and nothing re-arms.
- Start while busy: restart. The output is forced 0 at N+1, unless D=0, in which case it is high at N+1. Counters reload.
- Channels are independent after start. Equal D/P values give edge-coincident outputs on the same cycle.
- All counters are CW bits. No wrap within a valid config. The pulse count compares for equality and stops at C.
- Outputs come from flops, with no combinational path from inputs to outputs.

Test Plan:
- Reset, no start, 1000 cycles -> sync0..2=0, busy=3'b000 throughout.
- ch0 D=0,W=5,P=15,C=3; start at edge N -> sync0 high N+1..N+5, N+16..N+20, N+31..N+35; busy[0] 0 from N+36; ch1/ch2 run defaults (P=48_000, W=1, continuous).
- ch1 D=10,W=5,P=10,C=0; start at N, stop at N+100 -> first rise N+11, rises every 10 cycles; sync1=0 and busy[1]=0 from N+101; start+stop same cycle -> busy stays 0.
- ch2 W=20,P=10,C=2 -> period clamped to 21: rises at N+1 and N+22, each 20 cycles wide; W=0 -> 1-cycle pulses.
- Running ch2 P=4800; write period=100 mid-run -> interval stays 4800; a second start applies 100 and output is restart-aligned to the new start. cntr_module min/max for sync2 reads 4800 before the restart.
- Drop rst asynchronously mid-HIGH on all channels -> outputs 0 immediately without a clk edge; after release, shadow regs hold DEF_* and no pulses until start.

Source files
------------

// File: rtl/sync_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : sync_pulse_gen
// Purpose  : Programmable three-channel sync pulse transmitter. Each channel
//            has a delay from start, a pulse width, a rise-to-rise period and
//            a pulse count (0 = continuous). A common start/stop keeps all
//            channels phase-aligned. Config goes to shadow registers and is
//            copied to the active registers only when start is sampled.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-low reset
//            start        - one-cycle strobe, loads active config, arms channels
//            stop         - one-cycle strobe, aborts all channels (wins over start)
//            cfg_we       - shadow register write enable
//            cfg_ch       - channel select 0..2 (3 ignored)
//            cfg_addr     - 0=delay 1=width 2=period 3=count
//            cfg_data     - write data
//            sync0..sync2 - registered pulse outputs
//            busy         - per-channel active flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_pulse_gen #(
  parameter int unsigned CW         = 32,
  parameter int unsigned DEF_DELAY  = 0,
  parameter int unsigned DEF_WIDTH  = 1,
  parameter int unsigned DEF_PERIOD = 48_000,
  parameter int unsigned DEF_COUNT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_ch,
  input  logic [1:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          sync0,
  output logic          sync1,
  output logic          sync2,
  output logic [2:0]    busy
);

  localparam logic [CW-1:0] c_def_delay  = CW'(DEF_DELAY);
  localparam logic [CW-1:0] c_def_width  = CW'(DEF_WIDTH);
  localparam logic [CW-1:0] c_def_period = CW'(DEF_PERIOD);
  localparam logic [CW-1:0] c_def_count  = CW'(DEF_COUNT);
  localparam logic [CW-1:0] c_one        = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  logic [2:0] w_sync;
  logic [2:0] w_busy;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [CW-1:0] r_sh_delay;
    logic [CW-1:0] r_sh_width;
    logic [CW-1:0] r_sh_period;
    logic [CW-1:0] r_sh_count;

    logic [CW-1:0] r_delay;
    logic [CW-1:0] r_width;
    logic [CW-1:0] r_low;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_phase;   // cycles spent in the current state, 1-based
    logic [CW-1:0] r_pulses;  // rising edges produced since start
    state_t        r_state;
    logic          r_sync;
    logic          r_busy;

    logic          w_wr;
    logic [CW-1:0] w_san_width;
    logic [CW-1:0] w_san_period;
    logic [CW-1:0] w_san_low;

    assign w_wr = cfg_we && (cfg_ch == 2'(gi));

    // Width 0 behaves as 1; period is forced above width so LOW lasts >= 1.
    assign w_san_width  = (r_sh_width == '0) ? c_one : r_sh_width;
    assign w_san_period = (r_sh_period <= w_san_width) ? (w_san_width + c_one)
                                                       : r_sh_period;
    assign w_san_low    = w_san_period - w_san_width;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sh_delay  <= c_def_delay;
        r_sh_width  <= c_def_width;
        r_sh_period <= c_def_period;
        r_sh_count  <= c_def_count;
      end else if (w_wr) begin
        case (cfg_addr)
          2'd0:    r_sh_delay  <= cfg_data;
          2'd1:    r_sh_width  <= cfg_data;
          2'd2:    r_sh_period <= cfg_data;
          default: r_sh_count  <= cfg_data;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state  <= ST_IDLE;
        r_sync   <= 1'b0;
        r_busy   <= 1'b0;
        r_delay  <= '0;
        r_width  <= '0;
        r_low    <= '0;
        r_count  <= '0;
        r_phase  <= '0;
        r_pulses <= '0;
      end else if (stop) begin
        r_state <= ST_IDLE;
        r_sync  <= 1'b0;
        r_busy  <= 1'b0;
      end else if (start) begin
        // Shadow values read here are pre-edge, so a same-cycle write
        // only takes effect on the next start.
        r_delay <= r_sh_delay;
        r_width <= w_san_width;
        r_low   <= w_san_low;
        r_count <= r_sh_count;
        r_busy  <= 1'b1;
        r_phase <= c_one;
        if (r_sh_delay == '0) begin
          r_state  <= ST_HIGH;
          r_sync   <= 1'b1;
          r_pulses <= c_one;
        end else begin
          r_state  <= ST_DELAY;
          r_sync   <= 1'b0;
          r_pulses <= '0;
        end
      end else begin
        case (r_state)
          ST_DELAY: begin
            if (r_phase == r_delay) begin
              r_state  <= ST_HIGH;
              r_sync   <= 1'b1;
              r_phase  <= c_one;
              r_pulses <= r_pulses + c_one;
            end else begin
              r_phase <= r_phase + c_one;
            end
          end
          ST_HIGH: begin
            if (r_phase == r_width) begin
              r_sync  <= 1'b0;
              r_phase <= c_one;
              if ((r_count != '0) && (r_pulses == r_count)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_LOW;
              end
            end else begin
              r_phase <= r_phase + c_one;
            end
          end
          ST_LOW: begin
            if (r_phase == r_low) begin
              r_state  <= ST_HIGH;
              r_sync   <= 1'b1;
              r_phase  <= c_one;
              r_pulses <= r_pulses + c_one;
            end else begin
              r_phase <= r_phase + c_one;
            end
          end
          default: begin
            r_sync <= 1'b0;
            r_busy <= 1'b0;
          end
        endcase
      end
    end

    assign w_sync[gi] = r_sync;
    assign w_busy[gi] = r_busy;
  end

  assign sync0 = w_sync[0];
  assign sync1 = w_sync[1];
  assign sync2 = w_sync[2];
  assign busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sync_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_pulse_gen
// Purpose  : Self-checking bench for sync_pulse_gen. An arithmetic reference
//            model derives each channel's expected output from the number of
//            cycles since start; expectations are queued when stimulus is
//            driven and popped when the DUT output is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_pulse_gen;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          sync0;
  logic          sync1;
  logic          sync2;
  logic [2:0]    busy;

  always #5 clk = ~clk;

  sync_pulse_gen #(
    .CW(CW), .DEF_DELAY(0), .DEF_WIDTH(1), .DEF_PERIOD(48_000), .DEF_COUNT(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sync0(sync0), .sync1(sync1), .sync2(sync2), .busy(busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] sb_q[$];
  string      phase    = "init";

  longint     m_sh[3][4];
  longint     m_d[3], m_w[3], m_p[3], m_c[3], m_k[3];
  bit         m_run[3];
  logic [2:0] m_sync, m_busy;

  task automatic check(string tag, logic [5:0] obs, logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy/sync=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_sh[c][0] = 0; m_sh[c][1] = 1; m_sh[c][2] = 48_000; m_sh[c][3] = 0;
      m_run[c] = 1'b0; m_k[c] = 0;
    end
    m_sync = 3'b000;
    m_busy = 3'b000;
  endtask

  // Predict the outputs after the coming clock edge from the driven inputs.
  task automatic model_edge();
    longint t;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 3; c++) begin
      t = -1;
      if (stop) begin
        m_run[c] = 1'b0;
      end else if (start) begin
        m_d[c] = m_sh[c][0];
        m_w[c] = (m_sh[c][1] == 0) ? 1 : m_sh[c][1];
        m_p[c] = (m_sh[c][2] <= m_w[c]) ? m_w[c] + 1 : m_sh[c][2];
        m_c[c] = m_sh[c][3];
        m_run[c] = 1'b1;
        m_k[c] = 0;
      end
      if (m_run[c]) begin
        m_k[c]++;
        t = m_k[c] - 1 - m_d[c];
        if (m_c[c] != 0 && t >= (m_c[c] - 1) * m_p[c] + m_w[c]) m_run[c] = 1'b0;
      end
      m_busy[c] = m_run[c];
      m_sync[c] = m_run[c] && (t >= 0) && ((t % m_p[c]) < m_w[c]);
    end
    if (cfg_we && cfg_ch != 2'd3) m_sh[cfg_ch][cfg_addr] = longint'(cfg_data);
  endtask

  task automatic step();
    model_edge();
    sb_q.push_back({m_busy, m_sync});
    @(posedge clk);
    #1;
    check(phase, {busy, sync2, sync1, sync0}, sb_q.pop_front());
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(int ch, int addr, longint data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_addr = 2'(addr);
    cfg_data = CW'(data);
    step();
  endtask

  task automatic cfg(int ch, longint d, longint w, longint p, longint c);
    wr(ch, 0, d); wr(ch, 1, w); wr(ch, 2, p); wr(ch, 3, c);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_addr = 2'd0; cfg_data = '0;
    model_reset();
    #1;
    phase = "reset_hold";
    run(3);
    rst = 1'b1;
    phase = "idle_1000";
    run(1000);

    phase = "ch0_count3";
    cfg(0, 0, 5, 15, 3);
    start = 1'b1;
    run(60);

    phase = "ch1_cont_stop";
    cfg(1, 10, 5, 10, 0);
    start = 1'b1;
    run(100);
    stop = 1'b1;
    run(10);
    phase = "start_stop_same";
    start = 1'b1; stop = 1'b1;
    run(15);

    phase = "ch2_clamp";
    cfg(2, 0, 20, 10, 2);
    start = 1'b1;
    run(50);
    phase = "ch2_width0";
    cfg(2, 0, 0, 3, 3);
    wr(3, 2, 7);          // channel 3 write must be ignored
    start = 1'b1;
    run(15);

    phase = "shadow_midrun";
    cfg(2, 0, 3, 300, 0);
    start = 1'b1;
    run(50);
    wr(2, 2, 100);
    start = 1'b1;         // same-cycle write is not part of this run
    wr(2, 2, 200);
    run(320);
    phase = "restart_new_period";
    start = 1'b1;
    run(220);

    phase = "restart_delay";
    cfg(0, 4, 6, 12, 0);
    start = 1'b1;
    run(7);
    start = 1'b1;
    run(30);

    phase = "all_high";
    cfg(0, 0, 20, 40, 0);
    cfg(1, 0, 20, 40, 0);
    cfg(2, 0, 20, 40, 0);
    start = 1'b1;
    run(5);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {busy, sync2, sync1, sync0}, 6'b000000);
    model_reset();
    phase = "in_reset";
    run(3);
    rst = 1'b1;
    phase = "post_reset_idle";
    run(50);
    phase = "post_reset_defaults";
    start = 1'b1;
    run(10);
    stop = 1'b1;
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
